// File: rtl/cvs_led_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cvs_led_sequencer
//  Description : Front-panel controller for the CVS board. Debounces the
//                start/stop push-buttons, synchronises the direction switch
//                and steps a 4-bit walking-one LED pattern at a prescaled
//                rate, with a heartbeat that toggles on every step.
//  Ports       : clk        - 300 MHz buffered clock
//                reset      - asynchronous active-high reset
//                btn_start  - raw start button (active-high)
//                btn_stop   - raw stop button (active-high)
//                dir        - raw direction switch (0 = left, 1 = right)
//                led        - LED pattern (registered)
//                running    - high while sequencing (registered)
//                tick       - one-cycle step pulse (registered)
//                heartbeat  - toggles on every tick (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module cvs_led_sequencer #(
    parameter int TICK_DIV        = 200_000_000,
    parameter int DEBOUNCE_CYCLES = 3_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       dir,
    output logic [3:0] led,
    output logic       running,
    output logic       tick,
    output logic       heartbeat
);

    localparam int c_tick_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_db_w   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (bit 0 = start, bit 1 = stop)
    // ------------------------------------------------------------------
    logic [1:0] r_btn_meta;
    logic [1:0] r_btn_sync;
    logic       r_dir_meta;
    logic       r_dir_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_meta <= 2'b00;
            r_btn_sync <= 2'b00;
            r_dir_meta <= 1'b0;
            r_dir_sync <= 1'b0;
        end else begin
            r_btn_meta <= {btn_stop, btn_start};
            r_btn_sync <= r_btn_meta;
            r_dir_meta <= dir;
            r_dir_sync <= r_dir_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce + press-pulse generation, one instance per button
    // ------------------------------------------------------------------
    logic [1:0] w_press;

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [c_db_w-1:0] r_cnt;
        logic              r_deb;
        logic              r_deb_d;
        logic              r_pulse;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt   <= '0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                if (r_btn_sync[gi] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    // The increment would reach DEBOUNCE_CYCLES: accept the level.
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_deb_d <= r_deb;
                // Pulse lands in the cycle after the debounced level rises.
                r_pulse <= r_deb & ~r_deb_d;
            end
        end

        assign w_press[gi] = r_pulse;
    end

    logic w_start_p;
    logic w_stop_p;
    assign w_start_p = w_press[0];
    assign w_stop_p  = w_press[1];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_led;
    logic [3:0]          w_led_next;
    logic [c_tick_w-1:0] r_presc;
    logic                r_tick;
    logic                r_heartbeat;
    logic                r_running;
    logic                w_tick_event;
    logic                w_enter_run;

    // Step event is decoded one cycle ahead so the registered tick and the
    // rotated LED value appear on the same edge.
    assign w_tick_event = (r_state == ST_RUN) && (r_presc == c_tick_last);

    always_comb begin
        w_state_next = r_state;
        w_led_next   = r_led;
        case (r_state)
            ST_IDLE: begin
                w_led_next = 4'b0000;
                // Stop has priority over a simultaneous start.
                if (!w_stop_p && w_start_p) begin
                    w_state_next = ST_RUN;
                    w_led_next   = 4'b0001;
                end
            end
            ST_RUN: begin
                if (w_stop_p) begin
                    w_state_next = ST_PAUSED;
                end else if (w_tick_event) begin
                    w_led_next = r_dir_sync ? {r_led[0], r_led[3:1]}
                                            : {r_led[2:0], r_led[3]};
                end
            end
            ST_PAUSED: begin
                if (w_stop_p) begin
                    w_state_next = ST_IDLE;
                    w_led_next   = 4'b0000;
                end else if (w_start_p) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_led_next   = 4'b0000;
            end
        endcase
    end

    assign w_enter_run = (w_state_next == ST_RUN) && (r_state != ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_led       <= 4'b0000;
            r_running   <= 1'b0;
            r_presc     <= '0;
            r_tick      <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_led     <= w_led_next;
            r_running <= (w_state_next == ST_RUN);
            if (w_enter_run) begin
                r_presc <= '0;
            end else if (r_state == ST_RUN) begin
                r_presc <= w_tick_event ? '0 : r_presc + 1'b1;
            end
            // Tick and heartbeat follow the prescaler even if stop wins.
            r_tick      <= w_tick_event;
            r_heartbeat <= r_heartbeat ^ w_tick_event;
        end
    end

    assign led       = r_led;
    assign running   = r_running;
    assign tick      = r_tick;
    assign heartbeat = r_heartbeat;

endmodule
`default_nettype wire

// File: tb/tb_cvs_led_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cvs_led_sequencer
//  Description : Scoreboard bench for cvs_led_sequencer with TICK_DIV=8 and
//                DEBOUNCE_CYCLES=4. Stimulus pushes expected output events
//                (cycle, led, running, tick, heartbeat); a monitor pops one
//                whenever the DUT shows a tick or a led/running/heartbeat change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvs_led_sequencer;

    logic       clk;
    logic       reset;
    logic       btn_start;
    logic       btn_stop;
    logic       dir;
    logic [3:0] led;
    logic       running;
    logic       tick;
    logic       heartbeat;

    cvs_led_sequencer #(
        .TICK_DIV        (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .dir       (dir),
        .led       (led),
        .running   (running),
        .tick      (tick),
        .heartbeat (heartbeat)
    );

    initial clk = 1'b0;
    always #1.6665 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [3:0] led;
        logic       run;
        logic       tk;
        logic       hb;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    logic [3:0] prev_led = 4'b0;
    logic       prev_run = 1'b0;
    logic       prev_hb  = 1'b0;
    exp_t       e;

    task automatic push(input int c, input logic [3:0] l, input logic r,
                        input logic t, input logic h);
        exp_t x;
        x.cyc = c; x.led = l; x.run = r; x.tk = t; x.hb = h;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: any tick or visible output change is one event.
    always @(negedge clk) begin
        if (mon_en && (tick || led !== prev_led || running !== prev_run || heartbeat !== prev_hb)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: cyc=%0d led=%b run=%b tick=%b hb=%b, required no event",
                         cyc, led, running, tick, heartbeat);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.led !== led || e.run !== running ||
                    e.tk !== tick || e.hb !== heartbeat) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d led=%b run=%b tick=%b hb=%b required cyc=%0d led=%b run=%b tick=%b hb=%b",
                             cyc, led, running, tick, heartbeat, e.cyc, e.led, e.run, e.tk, e.hb);
                end
            end
        end
        prev_led = led;
        prev_run = running;
        prev_hb  = heartbeat;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int n, p, q, r, s, t, u, w;

    initial begin
        reset = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; dir = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", {28'd0, led}, 32'd0);
        check("reset_running", {31'd0, running}, 32'd0);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_heartbeat", {31'd0, heartbeat}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_led", {28'd0, led}, 32'd0);
        check("post_reset_running", {31'd0, running}, 32'd0);
        mon_en = 1'b1;

        // Start, left rotation, then direction switch to right
        @(negedge clk);
        n = cyc;
        btn_start = 1'b1;
        push(n+8,  4'b0001, 1, 0, 0);
        push(n+16, 4'b0010, 1, 1, 1);
        push(n+24, 4'b0100, 1, 1, 0);
        push(n+32, 4'b1000, 1, 1, 1);
        push(n+40, 4'b0001, 1, 1, 0);
        push(n+48, 4'b0010, 1, 1, 1);
        push(n+56, 4'b0100, 1, 1, 0);
        wait_until(n+20); btn_start = 1'b0;
        wait_until(n+57); dir = 1'b1;
        push(n+64, 4'b0010, 1, 1, 1);
        push(n+72, 4'b0001, 1, 1, 0);
        push(n+80, 4'b1000, 1, 1, 1);

        // Pause, long hold, resume, pause, stop to idle
        wait_until(n+81); btn_stop = 1'b1;
        push(n+88, 4'b0100, 1, 1, 0);
        push(n+89, 4'b0100, 0, 0, 0);
        wait_until(n+91); btn_stop = 1'b0;
        p = n + 135;
        wait_until(p); btn_start = 1'b1;
        push(p+8,  4'b0100, 1, 0, 0);
        push(p+16, 4'b0010, 1, 1, 1);
        push(p+24, 4'b0001, 1, 1, 0);
        push(p+32, 4'b1000, 1, 1, 1);
        push(p+33, 4'b1000, 0, 0, 1);
        wait_until(p+10); btn_start = 1'b0;
        q = p + 25;
        wait_until(q); btn_stop = 1'b1;
        wait_until(q+6); btn_stop = 1'b0;
        r = q + 20;
        wait_until(r); btn_stop = 1'b1;
        push(r+8, 4'b0000, 0, 0, 1);
        wait_until(r+10); btn_stop = 1'b0;

        // Short glitch on start: no press
        wait_until(r+30);
        s = cyc;
        btn_start = 1'b1;
        wait_until(s+2); btn_start = 1'b0;
        wait_until(s+25);
        check("glitch_running", {31'd0, running}, 32'd0);
        check("glitch_led", {28'd0, led}, 32'd0);

        // Start and stop together from idle: stop wins
        t = cyc;
        btn_start = 1'b1; btn_stop = 1'b1;
        wait_until(t+10); btn_start = 1'b0; btn_stop = 1'b0;
        wait_until(t+30);
        check("both_running", {31'd0, running}, 32'd0);
        check("both_led", {28'd0, led}, 32'd0);

        // Stop pulse aligned with a tick: no rotation, tick/heartbeat still fire
        u = cyc;
        btn_start = 1'b1;
        push(u+8,  4'b0001, 1, 0, 1);
        push(u+16, 4'b1000, 1, 1, 0);
        push(u+24, 4'b1000, 0, 1, 1);
        wait_until(u+10); btn_start = 1'b0;
        wait_until(u+16); btn_stop = 1'b1;
        wait_until(u+26); btn_stop = 1'b0;

        // Asynchronous reset in RUN with led=1000
        wait_until(u+40);
        w = cyc;
        btn_start = 1'b1;
        push(w+8, 4'b1000, 1, 0, 1);
        wait_until(w+9); btn_start = 1'b0;
        wait_until(w+11);
        check("pre_reset_led", {28'd0, led}, 32'h8);
        #0.5;
        mon_en = 1'b0;
        reset  = 1'b1;
        #0.2;
        check("async_reset_led", {28'd0, led}, 32'd0);
        check("async_reset_running", {31'd0, running}, 32'd0);
        check("async_reset_heartbeat", {31'd0, heartbeat}, 32'd0);
        check("async_reset_tick", {31'd0, tick}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_after_reset_running", {31'd0, running}, 32'd0);
        check("idle_after_reset_led", {28'd0, led}, 32'd0);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none required cyc=%0d led=%b run=%b tick=%b hb=%b",
                     e.cyc, e.led, e.run, e.tk, e.hb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
